// File: rtl/mips_fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory req/rvalid handshake plus control-unit side.
// Pure wiring, no latency; stall from downstream holds the fetch stage in VALID.
// Optional misalign_err exists only when FETCH_MISALIGN_TRAP_EN is defined.
interface mips_fetch_stage_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              imem_rvalid;
    logic              stall;
    logic              pcsr;
    logic              jump;
    logic [31:0]       instr;
    logic              instr_valid;
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic              misalign_err;
`endif

    modport master (
        output imem_req, imem_addr, instr, instr_valid, opcode, funct, pc, pc_plus4,
        input  imem_rdata, imem_rvalid, stall, pcsr, jump
`ifdef FETCH_MISALIGN_TRAP_EN
        , output misalign_err
`endif
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_valid, opcode, funct, pc, pc_plus4,
        output imem_rdata, imem_rvalid, stall, pcsr, jump
`ifdef FETCH_MISALIGN_TRAP_EN
        , input misalign_err
`endif
    );
endinterface

// File: rtl/mips_fetch_stage.sv
// MIPS instruction fetch: PC register, one-outstanding imem request, instruction register.
// Latency: >= 3 cycles per instruction (FETCH, WAIT, VALID); WAIT lasts until imem_rvalid.
// Backpressure: stall holds VALID with pc/instr frozen. FETCH_MISALIGN_TRAP_EN adds HALT + misalign_err.
module mips_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    mips_fetch_stage_if.master  fetch
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_VALID
`ifdef FETCH_MISALIGN_TRAP_EN
        , ST_HALT
`endif
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] branch_off;
    logic [ADDR_W-1:0] next_pc_raw;
    logic [ADDR_W-1:0] next_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic              misalign_q, misalign_d;
`endif

    assign pc_plus4   = pc_q + 32'd4;
    assign branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

    always_comb begin
        next_pc_raw = pc_plus4;
        if (fetch.jump) begin
            next_pc_raw = {pc_plus4[ADDR_W-1:ADDR_W-4], instr_q[25:0], 2'b00};
        end else if (fetch.pcsr) begin
            next_pc_raw = pc_plus4 + branch_off;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    assign next_pc = next_pc_raw;
`else
    // Without the trap a misaligned RESET_PC is silently realigned on the first advance.
    assign next_pc = {next_pc_raw[ADDR_W-1:2], 2'b00};
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT: begin
                if (fetch.imem_rvalid) begin
                    instr_d = fetch.imem_rdata;
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
                if (!fetch.stall) begin
                    pc_d    = next_pc;
                    state_d = ST_FETCH;
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (next_pc[1:0] != 2'b00) begin
                        state_d    = ST_HALT;
                        misalign_d = 1'b1;
                    end
`endif
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            ST_HALT:  state_d = ST_HALT;
`endif
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    // Outputs depend only on registered state, so pcsr/jump never reach imem_req.
    assign fetch.imem_req    = (state_q == ST_FETCH);
    assign fetch.imem_addr   = pc_q;
    assign fetch.instr       = instr_q;
    assign fetch.instr_valid = (state_q == ST_VALID);
    assign fetch.opcode      = instr_q[31:26];
    assign fetch.funct       = instr_q[5:0];
    assign fetch.pc          = pc_q;
    assign fetch.pc_plus4    = pc_plus4;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign fetch.misalign_err = misalign_q;
`endif

endmodule
